// File: rtl/rv32_pc_pkg.sv
// Shared constants for the RV32 fetch program counter.
// Widths, reset vector default, sequential step and word-alignment mask.
package rv32_pc_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;
    localparam int          PC_STEP      = 4;
    localparam logic [31:0] ALIGN_MASK   = ~32'h3;

endpackage

// File: rtl/rv32_program_counter_if.sv
// Redirect request from EX and fetch-address outputs of the program counter.
// The master drives redirects; the slave (program counter) drives pc and pc_plus_4.
interface rv32_program_counter_if #(
    parameter int XLEN = rv32_pc_pkg::XLEN
);
    import rv32_pc_pkg::*;

    logic [XLEN-1:0] branch_address;
    logic            branch_enable;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus_4;

    modport master (
        output branch_address,
        output branch_enable,
        input  pc,
        input  pc_plus_4
    );

    modport slave (
        input  branch_address,
        input  branch_enable,
        output pc,
        output pc_plus_4
    );

endinterface

// File: rtl/rv32_program_counter_pc_incrementer.sv
// Pure combinational PC adder; one result feeds both pc_plus_4 and the
// sequential next-pc, wrapping modulo 2^XLEN.
module pc_incrementer #(
    parameter int XLEN = rv32_pc_pkg::XLEN,
    parameter int STEP = rv32_pc_pkg::PC_STEP
) (
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pc_next
);
    import rv32_pc_pkg::*;

    assign pc_next = pc + XLEN'(STEP);

endmodule

// File: rtl/rv32_program_counter.sv
// IF-stage fetch address register: loads a word-aligned redirect target or
// advances by PC_STEP each edge; asynchronous active-low reset to RESET_VECTOR.
module rv32_program_counter #(
    parameter int              XLEN         = rv32_pc_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(rv32_pc_pkg::RESET_VECTOR),
    parameter int              PC_STEP      = rv32_pc_pkg::PC_STEP
) (
    input  logic                 clock,
    input  logic                 reset,
    rv32_program_counter_if.slave bus
);
    import rv32_pc_pkg::*;

    // Mask built from the inverted low-bit pattern so it scales with XLEN.
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(~ALIGN_MASK);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_inc;
    logic [XLEN-1:0] pc_d;

    pc_incrementer #(
        .XLEN (XLEN),
        .STEP (PC_STEP)
    ) u_incrementer (
        .pc      (pc_q),
        .pc_next (pc_inc)
    );

    // The address only reaches the mux output when selected, so an X on
    // branch_address cannot leak into pc while branch_enable is low.
    always_comb begin
        pc_d = pc_inc;
        if (bus.branch_enable) begin
            pc_d = bus.branch_address & WORD_MASK;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.pc_plus_4 = pc_inc;

endmodule

// File: tb/tb_rv32_program_counter.sv
// Scoreboarded directed bench for rv32_program_counter: stimulus queues the
// expected pc / pc_plus_4, a monitor process pops and compares.
module tb_rv32_program_counter;
    import rv32_pc_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] pc_plus_4;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b0;

    exp_t sb[$];
    event check_ev;
    int   checks = 0;
    int   passed = 0;

    rv32_program_counter_if #(.XLEN(32)) bus ();

    rv32_program_counter #(
        .XLEN         (32),
        .RESET_VECTOR (32'h0000_0000),
        .PC_STEP      (4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic expect_pc(input string name, input logic [31:0] pc);
        exp_t e;
        e.name      = name;
        e.pc        = pc;
        e.pc_plus_4 = pc + 32'd4;
        sb.push_back(e);
        -> check_ev;
    endtask

    task automatic step(input string name, input logic [31:0] pc);
        @(posedge clock);
        #1;
        expect_pc(name, pc);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(check_ev);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if (bus.pc !== e.pc)
                    $display("FAIL %s pc: got %h expected %h", e.name, bus.pc, e.pc);
                else
                    passed++;
                checks++;
                if (bus.pc_plus_4 !== e.pc_plus_4)
                    $display("FAIL %s pc_plus_4: got %h expected %h", e.name, bus.pc_plus_4, e.pc_plus_4);
                else
                    passed++;
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        bus.branch_address = 32'd100;
        bus.branch_enable  = 1'b0;

        // Reset held: immediate value, ignored edges
        #1;
        expect_pc("reset_async", 32'h0);
        step("reset_hold_edge1", 32'h0);
        step("reset_hold_edge2", 32'h0);

        // Sequential fetch
        @(negedge clock);
        reset = 1'b1;
        for (int i = 1; i <= 5; i++) step($sformatf("seq_%0d", i), 32'(i * 4));

        // Branch to 0xC8 for one edge
        @(negedge clock);
        bus.branch_address = 32'h0000_00C8;
        bus.branch_enable  = 1'b1;
        step("branch_c8", 32'h0000_00C8);
        @(negedge clock);
        bus.branch_enable = 1'b0;
        step("after_branch_1", 32'h0000_00CC);
        step("after_branch_2", 32'h0000_00D0);

        // Misaligned target is forced to a word boundary
        @(negedge clock);
        bus.branch_address = 32'h0000_0103;
        bus.branch_enable  = 1'b1;
        step("misaligned", 32'h0000_0100);

        // Walk up to 0xE0, then reset between edges
        @(negedge clock);
        bus.branch_address = 32'h0000_00D8;
        step("to_d8", 32'h0000_00D8);
        @(negedge clock);
        bus.branch_enable = 1'b0;
        step("seq_dc", 32'h0000_00DC);
        step("seq_e0", 32'h0000_00E0);
        @(negedge clock);
        #2;
        reset = 1'b0;
        #1;
        expect_pc("midrun_reset_async", 32'h0);
        step("midrun_reset_edge", 32'h0);
        @(negedge clock);
        reset = 1'b1;
        step("post_reset_4", 32'h4);
        step("post_reset_8", 32'h8);

        // Pulse that does not span an edge is ignored
        @(negedge clock);
        bus.branch_address = 32'h0000_0500;
        bus.branch_enable  = 1'b1;
        #2;
        bus.branch_enable  = 1'b0;
        step("short_pulse", 32'hC);

        // Held enable reloads the same target
        @(negedge clock);
        bus.branch_address = 32'h0000_0040;
        bus.branch_enable  = 1'b1;
        for (int i = 0; i < 3; i++) step($sformatf("held_%0d", i), 32'h0000_0040);

        // Wrap at the top of the address space
        @(negedge clock);
        bus.branch_address = 32'hFFFF_FFFC;
        step("top_of_space", 32'hFFFF_FFFC);
        @(negedge clock);
        bus.branch_enable = 1'b0;
        step("wrap", 32'h0);

        // X on branch_address with enable low must not propagate
        @(negedge clock);
        bus.branch_address = 'x;
        step("x_addr_ignored", 32'h4);

        // Reset wins over branch_enable
        @(negedge clock);
        bus.branch_address = 32'h0000_0080;
        bus.branch_enable  = 1'b1;
        reset = 1'b0;
        #1;
        expect_pc("prio_reset_async", 32'h0);
        step("prio_reset_edge", 32'h0);
        @(negedge clock);
        bus.branch_enable = 1'b0;
        reset = 1'b1;
        step("prio_release", 32'h4);

        #2;
        checks++;
        if (sb.size() != 0)
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        else
            passed++;

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
